// File: rtl/uart_mem_pkg.sv
// Shared definitions for the UART <-> data-memory loader/dumper:
// FSM state encoding, word geometry and byte-lane order.
package uart_mem_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

   typedef enum logic [2:0] {
      LOAD,
      WRITE,
      RUN,
      RD,
      WAIT,
      SEND,
      CKS,
      FIN
   } state_e;

   typedef enum logic {
      LANE_BIG_ENDIAN,
      LANE_LITTLE_ENDIAN
   } lane_order_e;

   // First byte on the wire lands in (and leaves from) bits [31:24].
   localparam lane_order_e LANE_ORDER = LANE_BIG_ENDIAN;

   // Index width that stays legal when a count of one is requested.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/word_packer.sv
// Four-byte shift register plus byte counter, shared by the load path
// (bytes shifted in from UART RX) and the dump path (word loaded from
// memory, bytes shifted out to UART TX).
module word_packer
   import uart_mem_pkg::*;
(
   input  logic        sysclk,
   input  logic        reset,
   input  logic        clear,
   input  logic        load,
   input  logic        shift,
   input  logic [7:0]  byte_in,
   input  logic [31:0] word_in,
   output logic [31:0] word_next,
   output logic [7:0]  byte_out,
   output logic        last_byte
);

   localparam bit MSB_FIRST = (LANE_ORDER == LANE_BIG_ENDIAN);

   logic [31:0]           word_q;
   logic [BYTE_IDX_W-1:0] byte_idx;

   // Next shifted word and the byte sitting in the outgoing lane
   always_comb begin
      // NOTE: every output is given a default first so no path leaves it unassigned and no latch is inferred.
      word_next = {byte_in, word_q[31:8]};
      byte_out  = word_q[7:0];
      if (MSB_FIRST) begin
         word_next = {word_q[23:0], byte_in};
         byte_out  = word_q[31:24];
      end
   end

   assign last_byte = (byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

   // Word register and byte counter; the counter wraps to 0 after the last byte
   always_ff @(posedge sysclk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         word_q   <= '0;
         byte_idx <= '0;
      end else if (clear) begin
         byte_idx <= '0;
      end else if (load) begin
         word_q   <= word_in;
         byte_idx <= '0;
      end else if (shift) begin
         word_q   <= word_next;
         byte_idx <= byte_idx + 1'b1;
      end
   end

endmodule

// File: rtl/uart_mem_loader.sv
// Sequences the UART <-> data-memory path: loads WORD_COUNT words from
// UART RX after reset while holding the CPU off the memory, then releases
// the CPU and dumps the same region to UART TX on each mem2uart rising edge.
// Optional build macro DUMP_CHECKSUM_EN appends an XOR checksum byte to
// every dump.
module uart_mem_loader
   import uart_mem_pkg::*;
#(
   parameter int              WORD_COUNT = 25,
   parameter longint unsigned BASE_ADDR  = 0,
   parameter int              ADDR_W     = 32
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              tx_ready,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              mem2uart,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   input  logic [31:0]       mem_rdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              dump_done
);

   localparam int                IDX_W    = idx_width(WORD_COUNT);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_COUNT - 1);
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

   state_e           state;
   logic [IDX_W-1:0] word_idx;
   logic             m2u_q;
   logic             m2u_rise;
   logic             tx_go;

   logic             pk_clear;
   logic             pk_load;
   logic             pk_shift;
   logic [31:0]      pk_word_next;
   logic [7:0]       pk_byte_out;
   logic             pk_last;

`ifdef DUMP_CHECKSUM_EN
   logic [7:0]       xor_acc;
`endif

   // Byte address of word idx; wraps modulo 2^ADDR_W
   function automatic logic [ADDR_W-1:0] word_addr(input logic [IDX_W-1:0] idx);
      return BASE + ADDR_W'(idx) * ADDR_W'(BYTES_PER_WORD);
   endfunction

   assign m2u_rise = mem2uart & ~m2u_q;

   // tx_start is registered, so in the cycle it is high the UART has not yet
   // had a chance to drop tx_ready; never launch two bytes back to back.
   assign tx_go = tx_ready & ~tx_start;

   word_packer u_packer (
      .sysclk    (sysclk),
      .reset     (reset),
      .clear     (pk_clear),
      .load      (pk_load),
      .shift     (pk_shift),
      .byte_in   (rx_data),
      .word_in   (mem_rdata),
      .word_next (pk_word_next),
      .byte_out  (pk_byte_out),
      .last_byte (pk_last)
   );

   // Packer control decoded from the current state
   always_comb begin
      pk_clear = 1'b0;
      pk_load  = 1'b0;
      pk_shift = 1'b0;
      case (state)
         LOAD:    pk_shift = rx_valid;
         // a byte arriving during the write is byte 0 of the next word
         WRITE:   pk_shift = rx_valid && (word_idx != LAST_IDX);
         RUN:     pk_clear = m2u_rise;
         WAIT:    pk_load  = 1'b1;
         SEND:    pk_shift = tx_go;
         default: ;
      endcase
   end

   // Main sequencer: load/dump FSM, address generation and CPU arbitration
   always_ff @(posedge sysclk) begin
      if (reset) begin
         state     <= LOAD;
         word_idx  <= '0;
         m2u_q     <= 1'b0;
         cpu_hold  <= 1'b1;
         load_done <= 1'b0;
         dump_done <= 1'b0;
         tx_start  <= 1'b0;
         tx_data   <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= BASE;
         mem_wdata <= '0;
`ifdef DUMP_CHECKSUM_EN
         xor_acc   <= '0;
`endif
      end else begin
         m2u_q     <= mem2uart;
         tx_start  <= 1'b0;
         dump_done <= 1'b0;
         mem_we    <= 1'b0;

         case (state)
            LOAD: begin
               if (rx_valid && pk_last) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= word_addr(word_idx);
                  mem_wdata <= pk_word_next;
                  state     <= WRITE;
               end
            end

            WRITE: begin
               if (word_idx == LAST_IDX) begin
                  load_done <= 1'b1;
                  cpu_hold  <= 1'b0;
                  state     <= RUN;
               end else begin
                  word_idx <= word_idx + 1'b1;
                  state    <= LOAD;
               end
            end

            RUN: begin
               if (m2u_rise) begin
                  cpu_hold <= 1'b1;
                  word_idx <= '0;
                  mem_addr <= BASE;
`ifdef DUMP_CHECKSUM_EN
                  xor_acc  <= '0;
`endif
                  state    <= RD;
               end
            end

            RD:   state <= WAIT;

            WAIT: state <= SEND;

            SEND: begin
               if (tx_go) begin
                  tx_start <= 1'b1;
                  tx_data  <= pk_byte_out;
`ifdef DUMP_CHECKSUM_EN
                  xor_acc  <= xor_acc ^ pk_byte_out;
`endif
                  if (pk_last) begin
                     if (word_idx == LAST_IDX) begin
`ifdef DUMP_CHECKSUM_EN
                        state <= CKS;
`else
                        state <= FIN;
`endif
                     end else begin
                        word_idx <= word_idx + 1'b1;
                        mem_addr <= word_addr(word_idx + 1'b1);
                        state    <= RD;
                     end
                  end
               end
            end

`ifdef DUMP_CHECKSUM_EN
            CKS: begin
               if (tx_go) begin
                  tx_start <= 1'b1;
                  tx_data  <= xor_acc;
                  state    <= FIN;
               end
            end
`endif

            FIN: begin
               dump_done <= 1'b1;
               cpu_hold  <= 1'b0;
               state     <= RUN;
            end

            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench for uart_mem_loader: reset values, abort-and-reload,
// full load of bytes 0x00..0x63, ignored mem2uart during load, dump with a
// mid-word tx_ready stall, and the optional checksum byte (DUMP_CHECKSUM_EN).
module tb_uart_mem_loader;

   localparam int              WORD_COUNT = 25;
   localparam longint unsigned BASE_ADDR  = 64'h40;
   localparam int              ADDR_W     = 32;
   localparam int              N_BYTES    = WORD_COUNT * 4;
`ifdef DUMP_CHECKSUM_EN
   localparam int              N_TX       = N_BYTES + 1;
`else
   localparam int              N_TX       = N_BYTES;
`endif

   logic              sysclk    = 1'b0;
   logic              reset     = 1'b1;
   logic              rx_valid  = 1'b0;
   logic [7:0]        rx_data   = '0;
   logic              tx_ready  = 1'b1;
   logic              mem2uart  = 1'b0;
   logic [31:0]       mem_rdata = '0;
   logic              tx_start;
   logic [7:0]        tx_data;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_we;
   logic              cpu_hold;
   logic              load_done;
   logic              dump_done;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  tx_q[$];
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          done_cnt   = 0;
   int          stall_viol = 0;
   logic        ready_prev = 1'b1;

   typedef struct {
      string       name;
      int          idx;
      logic [31:0] addr;
      logic [31:0] data;
   } wr_vec_t;

   wr_vec_t vecs[4];

   uart_mem_loader #(
      .WORD_COUNT (WORD_COUNT),
      .BASE_ADDR  (BASE_ADDR),
      .ADDR_W     (ADDR_W)
   ) dut (
      .sysclk    (sysclk),
      .reset     (reset),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .tx_ready  (tx_ready),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .mem2uart  (mem2uart),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .cpu_hold  (cpu_hold),
      .load_done (load_done),
      .dump_done (dump_done)
   );

   always #5 sysclk = ~sysclk;

   function automatic logic [31:0] exp_addr(input int k);
      return 32'(BASE_ADDR) + 32'(4 * k);
   endfunction

   function automatic bit ram_hit(input logic [31:0] a);
      return (a >= 32'(BASE_ADDR)) && (a[1:0] == 2'b00) &&
             (((a - 32'(BASE_ADDR)) >> 2) < 32'(WORD_COUNT));
   endfunction

   function automatic int ram_idx(input logic [31:0] a);
      return int'((a - 32'(BASE_ADDR)) >> 2);
   endfunction

   // Synchronous data memory: write on mem_we, read data one cycle after the address
   logic [31:0] ram [WORD_COUNT];
   // NOTE: the memory array is not reset; only words written by the loader are ever read back.
   always @(posedge sysclk) begin
      if (mem_we && ram_hit(mem_addr)) ram[ram_idx(mem_addr)] <= mem_wdata;
      mem_rdata <= ram_hit(mem_addr) ? ram[ram_idx(mem_addr)] : 32'hDEAD_BEEF;
   end

   // Output monitor, sampled on the falling edge away from DUT updates
   always @(negedge sysclk) begin
      if (tx_start) begin
         tx_q.push_back(tx_data);
         if (!tx_ready && !ready_prev) stall_viol++;
      end
      if (dump_done) done_cnt++;
      if (mem_we) begin
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_wdata);
      end
      ready_prev = tx_ready;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no completion, expected finish before 90000 cycles");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] wr_addr_at(input int i);
      return (i < wr_addr_q.size()) ? wr_addr_q[i] : 32'hxxxx_xxxx;
   endfunction

   function automatic logic [31:0] wr_data_at(input int i);
      return (i < wr_data_q.size()) ? wr_data_q[i] : 32'hxxxx_xxxx;
   endfunction

   function automatic logic [31:0] tx_at(input int i);
      return (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hxxxx_xxxx;
   endfunction

   task automatic step();
      @(posedge sysclk);
      #1;
   endtask

   task automatic sample();
      @(negedge sysclk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) step();
      rx_data  = b;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      tx_q.delete();
      wr_addr_q.delete();
      wr_data_q.delete();
      done_cnt   = 0;
      stall_viol = 0;
   endtask

   task automatic wait_tx(input int n, input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < max_cyc; c++) begin
         sample();
         if (tx_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit          ok;
      int          n_hold;
      logic [7:0]  seq [8];
      logic [7:0]  xsum;

      vecs[0] = '{"load word 0",  0,  exp_addr(0),  32'h0001_0203};
      vecs[1] = '{"load word 1",  1,  exp_addr(1),  32'h0405_0607};
      vecs[2] = '{"load word 12", 12, exp_addr(12), 32'h3031_3233};
      vecs[3] = '{"load word 24", 24, exp_addr(24), 32'h6061_6263};

      // ---- reset state ----
      repeat (3) step();
      sample();
      check("reset cpu_hold",  32'(cpu_hold),  1);
      check("reset mem_we",    32'(mem_we),    0);
      check("reset tx_start",  32'(tx_start),  0);
      check("reset load_done", 32'(load_done), 0);
      check("reset dump_done", 32'(dump_done), 0);
      check("reset mem_addr",  mem_addr,       exp_addr(0));
      check("reset mem_wdata", mem_wdata,      0);
      check("reset tx_data",   32'(tx_data),   0);
      step();
      reset = 1'b0;

      // ---- abort mid-load, then reload with a byte arriving during WRITE ----
      for (int i = 0; i < 6; i++) send_byte(8'h11 + 8'(i), 5);
      check("pre-abort word 0", wr_data_at(0), 32'h1112_1314);
      pulse_reset();
      sample();
      check("abort cpu_hold", 32'(cpu_hold), 1);
      check("abort mem_addr", mem_addr, exp_addr(0));
      step();
      seq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h01, 8'h02};
      for (int i = 0; i < 8; i++) send_byte(seq[i], 0);
      repeat (3) step();
      check("abort write count", wr_data_q.size(), 2);
      check("abort word 0 addr", wr_addr_at(0), exp_addr(0));
      check("abort word 0 data", wr_data_at(0), 32'hAABB_CCDD);
      check("abort word 1 addr", wr_addr_at(1), exp_addr(1));
      check("abort word 1 data", wr_data_at(1), 32'hEEFF_0102);

      // ---- full load of 0x00..0x63 with a mem2uart pulse during the load ----
      pulse_reset();
      for (int i = 0; i < N_BYTES; i++) begin
         send_byte(8'(i), 50);
         if (i == 10) begin
            mem2uart = 1'b1;
            repeat (3) step();
            mem2uart = 1'b0;
            sample();
            check("hold after load-time mem2uart", 32'(cpu_hold), 1);
            step();
         end
      end
      repeat (3) step();
      sample();
      check("load_done after load", 32'(load_done), 1);
      check("cpu_hold after load",  32'(cpu_hold),  0);
      check("load write count",     wr_data_q.size(), WORD_COUNT);
      check("no tx during load",    tx_q.size(), 0);
      check("no dump during load",  done_cnt, 0);
      for (int v = 0; v < 4; v++) begin
         check({vecs[v].name, " addr"}, wr_addr_at(vecs[v].idx), vecs[v].addr);
         check({vecs[v].name, " data"}, wr_data_at(vecs[v].idx), vecs[v].data);
      end

      // ---- dump with a 200-cycle mid-word tx_ready stall ----
      step();
      mem2uart = 1'b1;
      @(posedge sysclk);
      sample();
      check("dump cpu_hold within 1 cycle", 32'(cpu_hold), 1);
      wait_tx(1, 5, ok);
      check("first tx_start latency", 32'(ok), 1);
      wait_tx(42, 500, ok);
      check("reach byte 42", 32'(ok), 1);
      step();
      tx_ready = 1'b0;
      sample();
      n_hold = tx_q.size();
      repeat (200) step();
      check("no tx while stalled", tx_q.size(), n_hold);
      tx_ready = 1'b1;

      ok = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         sample();
         if (dump_done) begin
            ok = 1'b1;
            break;
         end
      end
      check("dump_done seen",           32'(ok), 1);
      check("tx count at dump_done",    tx_q.size(), N_TX);
      sample();
      check("cpu_hold after dump_done", 32'(cpu_hold), 0);
      check("dump_done is one cycle",   32'(dump_done), 0);

      repeat (20) step();
      sample();
      check("held mem2uart no retrigger", tx_q.size(), N_TX);
      check("single dump_done pulse",     done_cnt, 1);
      check("cpu_hold released",          32'(cpu_hold), 0);
      check("tx_start while tx_ready low", stall_viol, 0);

      for (int i = 0; i < N_BYTES; i++)
         check($sformatf("dump byte %0d", i), tx_at(i), 32'(i));
`ifdef DUMP_CHECKSUM_EN
      xsum = '0;
      for (int i = 0; i < N_BYTES; i++) xsum ^= 8'(i);
      check("checksum byte", tx_at(N_BYTES), 32'(xsum));
`endif
      mem2uart = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
